// File: rtl/bk_save_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_save_streamer_pkg: shared types and constants for the save path.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bk_save_streamer_pkg;

  localparam int WORDS_PER_SECTOR = 256;
  localparam int SKID_DEPTH       = 2;
  localparam int BK_ADDR_W        = 17;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  sector_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bk_save_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_save_if: control, backup-RAM, SD and stream signals of the saver. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bk_save_if;
  import bk_save_streamer_pkg::*;

  logic                 save_req;
  logic                 has_save;
  sector_t              ram_mask_file;
  logic                 cram_wr;
  logic [BK_ADDR_W-1:0] bk_addr;
  word_t                bk_q;
  sector_t              sd_lba;
  logic                 sd_wr;
  logic                 sd_ack;
  word_t                out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic                 dirty;

  modport slave (
    input  save_req, has_save, ram_mask_file, cram_wr, bk_q, sd_ack, out_ready,
    output bk_addr, sd_lba, sd_wr, out_data, out_valid, busy, done, dirty
  );

  modport master (
    output save_req, has_save, ram_mask_file, cram_wr, bk_q, sd_ack, out_ready,
    input  bk_addr, sd_lba, sd_wr, out_data, out_valid, busy, done, dirty
  );

endinterface
`default_nettype wire

// File: rtl/bk_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_skid_buffer: 2-entry valid/ready FIFO absorbing the RAM latency.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bk_skid_buffer
  import bk_save_streamer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             in_valid,
  input  wire logic [WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  wire logic             out_ready,
  output logic [1:0]            count
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign push      = in_valid && (count_q != 2'(SKID_DEPTH));
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bk_save_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_save_streamer: streams cart backup RAM to SD sector by sector.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bk_save_streamer
  import bk_save_streamer_pkg::*;
(
  input  wire logic clk_sys,
  input  wire logic reset,
  bk_save_if.slave  bus
);

  state_t  state_q, state_d;
  sector_t sector_q, sector_d;
  sector_t mask_q, mask_d;
  logic [7:0] word_idx_q, word_idx_d;
  logic    pend_q, pend_d;
  logic    dirty_q, dirty_d;
  logic    done_q, done_d;

  logic       issue, abort, start;
  logic       sk_valid, sk_pop, space;
  logic [1:0] sk_count;
  logic [2:0] occ_after;
  word_t      sk_data;

  bk_skid_buffer #(.WIDTH(16)) u_skid (
    .clk       (clk_sys),
    .rst       (reset),
    .flush     (abort),
    .in_valid  (pend_q),
    .in_data   (bus.bk_q),
    .out_valid (sk_valid),
    .out_data  (sk_data),
    .out_ready (bus.out_ready),
    .count     (sk_count)
  );

  // A read issued now lands next cycle, so only issue if the buffer will
  // hold at most one word once this cycle's push/pop have settled.
  assign sk_pop    = sk_valid && bus.out_ready;
  assign occ_after = {1'b0, sk_count} + {2'b0, pend_q} - {2'b0, sk_pop};
  assign space     = (occ_after < 3'd2);

  always_comb begin
    state_d    = state_q;
    sector_d   = sector_q;
    mask_d     = mask_q;
    word_idx_d = word_idx_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    abort      = 1'b0;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.save_req && bus.has_save) begin
          start      = 1'b1;
          sector_d   = '0;
          word_idx_d = '0;
          mask_d     = bus.ram_mask_file;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // Word 0 is fetched on the ack edge so the first word is out one cycle later.
        if (bus.sd_ack) begin
          issue      = 1'b1;
          word_idx_d = 8'd1;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!bus.sd_ack) begin
          abort      = 1'b1;
          word_idx_d = '0;
          state_d    = ST_IDLE;
        end else if (space) begin
          issue      = 1'b1;
          word_idx_d = word_idx_q + 8'd1;
          if (word_idx_q == 8'(WORDS_PER_SECTOR - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((sk_count == 2'd0) && !pend_q && !bus.sd_ack) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        word_idx_d = '0;
        if (sector_q == mask_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sector_d = sector_q + 8'd1;
          state_d  = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d = issue;

    if (bus.cram_wr) begin
      dirty_d = 1'b1;
    end else if (start) begin
      dirty_d = 1'b0;
    end else if (abort) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sector_q   <= '0;
      mask_q     <= '0;
      word_idx_q <= '0;
      pend_q     <= 1'b0;
      dirty_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sector_q   <= sector_d;
      mask_q     <= mask_d;
      word_idx_q <= word_idx_d;
      pend_q     <= pend_d;
      dirty_q    <= dirty_d;
      done_q     <= done_d;
    end
  end

  assign bus.bk_addr   = ((state_q == ST_REQ) || (state_q == ST_STREAM)) ?
                         {1'b0, sector_q, word_idx_q} : '0;
  assign bus.sd_lba    = sector_q;
  assign bus.sd_wr     = (state_q == ST_REQ) || (state_q == ST_STREAM);
  assign bus.out_data  = sk_data;
  assign bus.out_valid = sk_valid;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.dirty     = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_bk_save_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bk_save_streamer: directed bench with queue-based stream model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bk_save_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bk_save_if bus ();

  bk_save_streamer dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_w;
  logic [7:0]  exp_lba = 8'd0;
  int cyc = 0, ack_cyc = 0, sec_words = 0, acc_total = 0;
  int done_cnt = 0, ack_rises = 0;
  bit ack_prev = 1'b0, tput_mode = 1'b0, rand_ready = 1'b0;
  bit abort_arm = 1'b0, abort_seen = 1'b0;
  logic [15:0] first_word = '0, word257 = '0, last_word = '0;

  function automatic logic [15:0] ram_word(input logic [16:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3} ^ {15'd0, a[16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bk_addr"},   32'(bus.bk_addr),   32'd0);
    chk({tag, "_sd_lba"},    32'(bus.sd_lba),    32'd0);
    chk({tag, "_sd_wr"},     32'(bus.sd_wr),     32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_dirty"},     32'(bus.dirty),     32'd0);
  endtask

  // Backup RAM: data for the address seen this cycle appears next cycle.
  initial begin
    logic [16:0] a;
    bus.bk_q = '0;
    forever begin
      @(negedge clk);
      a = bus.bk_addr;
      @(posedge clk);
      #1 bus.bk_q = ram_word(a);
    end
  end

  // Sink
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // SD controller: ack 3 cycles after sd_wr, held until sd_wr drops.
  initial begin
    int dly;
    dly = 0;
    bus.sd_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.sd_ack = 1'b0;
        dly = 0;
      end else if (!bus.sd_ack) begin
        if (bus.sd_wr) begin
          dly++;
          if (dly == 3) begin
            bus.sd_ack = 1'b1;
            dly = 0;
          end
        end else begin
          dly = 0;
        end
      end else if (!bus.sd_wr) begin
        bus.sd_ack = 1'b0;
      end else if (abort_arm && bus.sd_lba == 8'd2 && sec_words >= 101) begin
        bus.sd_ack = 1'b0;
        abort_arm  = 1'b0;
        abort_seen = 1'b1;
      end
    end
  end

  // Compare process: every accepted word against the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.sd_ack && !ack_prev) begin
        chk("ack_lba", 32'(bus.sd_lba), 32'(exp_lba));
        chk("ack_sd_wr", 32'(bus.sd_wr), 32'd1);
        exp_lba++;
        ack_cyc = cyc;
        sec_words = 0;
        ack_rises++;
      end
      ack_prev = bus.sd_ack;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got 0x%0h expected no word (cycle %0d)", bus.out_data, cyc);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", 32'(bus.out_data), 32'(exp_w));
          if (acc_total == 0)    first_word = bus.out_data;
          if (acc_total == 257)  word257    = bus.out_data;
          if (acc_total == 4095) last_word  = bus.out_data;
          if (tput_mode && sec_words == 0)   chk("first_word_latency", 32'(cyc - ack_cyc), 32'd2);
          if (tput_mode && sec_words == 255) chk("sector_latency", 32'(cyc - ack_cyc), 32'd257);
          acc_total++;
          sec_words++;
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_busy_low", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic start_save(input logic [7:0] mask, input logic with_cram);
    @(posedge clk);
    #1;
    bus.save_req      = 1'b1;
    bus.ram_mask_file = mask;
    bus.cram_wr       = with_cram;
    if (bus.has_save && !bus.busy) begin
      exp_q.delete();
      for (int s = 0; s <= int'(mask); s++)
        for (int n = 0; n < 256; n++)
          exp_q.push_back(ram_word({1'b0, 8'(s), 8'(n)}));
      exp_lba   = 8'd0;
      acc_total = 0;
      ack_rises = 0;
    end
    @(posedge clk);
    #1;
    bus.save_req = 1'b0;
    bus.cram_wr  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(name, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    bit any_busy, any_wr, found;
    int d0;
    reset = 1'b1;
    bus.save_req = 1'b0;
    bus.has_save = 1'b1;
    bus.ram_mask_file = 8'd0;
    bus.cram_wr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Full 16-sector save at full throughput
    @(posedge clk);
    #1 bus.cram_wr = 1'b1;
    @(posedge clk);
    #1 bus.cram_wr = 1'b0;
    @(negedge clk);
    chk("cram_sets_dirty", 32'(bus.dirty), 32'd1);
    tput_mode = 1'b1;
    start_save(8'h0F, 1'b0);
    @(negedge clk);
    chk("start_clears_dirty", 32'(bus.dirty), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    wait_done(6000, "t1_done");
    tput_mode = 1'b0;
    chk("t1_words", 32'(acc_total), 32'd4096);
    chk("t1_sectors", 32'(ack_rises), 32'd16);
    chk("t1_first_word", 32'(first_word), 32'h5AC3);
    chk("t1_word257", 32'(word257), 32'h5BC2);
    chk("t1_last_word", 32'(last_word), 32'hA5CC);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    @(negedge clk);
    chk("t1_dirty_after", 32'(bus.dirty), 32'd0);

    // Random backpressure, mid-save mask change, cram_wr in sector 3, busy save_req
    rand_ready = 1'b1;
    start_save(8'h0F, 1'b0);
    repeat (20) @(posedge clk);
    #1 bus.ram_mask_file = 8'h03;
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      @(negedge clk);
      if (bus.sd_lba == 8'd3 && bus.sd_ack) found = 1'b1;
    end
    chk("t2_reach_sector3", 32'(found), 32'd1);
    @(posedge clk);
    #1 bus.cram_wr = 1'b1;
    @(posedge clk);
    #1 bus.cram_wr = 1'b0;
    start_save(8'h01, 1'b0);
    wait_done(20000, "t2_done");
    rand_ready = 1'b0;
    chk("t2_words", 32'(acc_total), 32'd4096);
    chk("t2_sectors", 32'(ack_rises), 32'd16);
    @(negedge clk);
    chk("t2_dirty_after", 32'(bus.dirty), 32'd1);

    // Single-sector saves: clean, then with cram_wr coincident with save_req
    start_save(8'h00, 1'b0);
    wait_done(1000, "t3a_done");
    @(negedge clk);
    chk("t3a_dirty", 32'(bus.dirty), 32'd0);
    chk("t3a_words", 32'(acc_total), 32'd256);
    start_save(8'h00, 1'b1);
    @(negedge clk);
    chk("t3b_dirty_at_start", 32'(bus.dirty), 32'd1);
    wait_done(1000, "t3b_done");
    @(negedge clk);
    chk("t3b_dirty_after", 32'(bus.dirty), 32'd1);

    // No battery RAM: request ignored
    bus.has_save = 1'b0;
    start_save(8'h0F, 1'b0);
    any_busy = 1'b0;
    any_wr   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy)  any_busy = 1'b1;
      if (bus.sd_wr) any_wr   = 1'b1;
    end
    chk("nosave_busy", 32'(any_busy), 32'd0);
    chk("nosave_sd_wr", 32'(any_wr), 32'd0);
    bus.has_save = 1'b1;

    // sd_ack dropped after word 100 of sector 2
    abort_arm  = 1'b1;
    abort_seen = 1'b0;
    start_save(8'h0F, 1'b0);
    @(negedge clk);
    chk("t5_dirty_cleared", 32'(bus.dirty), 32'd0);
    for (int i = 0; i < 3000 && !abort_seen; i++) begin
      @(posedge clk);
      #2;
    end
    chk("t5_abort_seen", 32'(abort_seen), 32'd1);
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("t5_idle", 32'(bus.busy), 32'd0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_sd_wr", 32'(bus.sd_wr), 32'd0);
    chk("t5_dirty", 32'(bus.dirty), 32'd1);
    chk("t5_words_before_abort", 32'(acc_total), 32'd614);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset in the middle of sector 0, then a fresh save
    start_save(8'h0F, 1'b0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    start_save(8'h00, 1'b0);
    wait_done(1000, "t6_done");
    chk("t6_words", 32'(acc_total), 32'd256);
    chk("t6_first_word", 32'(first_word), 32'h5AC3);
    chk("t6_sectors", 32'(ack_rises), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
